// File: rtl/dekatron_counter_if.sv
// Request/response bundle between the instruction/address sequencer and a
// dekatron counter chain: request, direction, load value, Ready and the BCD count.
interface dekatron_counter_if #(
  parameter int D_NUM = 3
);
  logic               Request;
  logic               Dec;
  logic               Set;
  logic [D_NUM*4-1:0] In;
  logic               Ready;
  logic [D_NUM*4-1:0] Out;

  modport master (output Request, Dec, Set, In, input Ready, Out);
  modport slave  (input Request, Dec, Set, In, output Ready, Out);
endinterface

// File: rtl/dekatron_counter.sv
// Multi-decade BCD up/down counter emulating a dekatron tube chain: one digit
// step (or a whole-word load) per STEP_CYCLES clocks, carries rippling upward.
module dekatron_counter #(
  parameter int                 D_NUM          = 3,
  parameter int                 TOP_LIMIT_MODE = 0,
  parameter logic [D_NUM*4-1:0] TOP_VALUE      = {D_NUM{4'h9}},
  parameter int                 STEP_CYCLES    = 10
) (
  input  logic             Clk,
  input  logic             Rst_n,
  dekatron_counter_if.slave bus
);
  localparam int W     = D_NUM * 4;
  localparam int IDX_W = (D_NUM > 1) ? $clog2(D_NUM) : 1;
  localparam int DIV_W = $clog2(STEP_CYCLES);

  typedef enum logic [1:0] {IDLE, LOAD, STEP} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             dec_q, dec_nxt;
  logic [W-1:0]     load_q, load_nxt;
  logic [W-1:0]     count_q, count_nxt;
  logic             tick;
  logic [3:0]       cur_digit;
  logic [4:0]       step_res;

  // Result is {carry, digit}; a non-decimal digit counts up as if it were 9.
  function automatic logic [4:0] inc_digit(input logic [3:0] d);
    if (d >= 4'd9) return {1'b1, 4'd0};
    return {1'b0, d + 4'd1};
  endfunction

  function automatic logic [4:0] dec_digit(input logic [3:0] d);
    if (d == 4'd0) return {1'b1, 4'd9};
    return {1'b0, d - 4'd1};
  endfunction

  assign tick      = (div_cnt == DIV_W'(STEP_CYCLES - 1));
  assign cur_digit = count_q[int'(idx)*4 +: 4];
  assign step_res  = dec_q ? dec_digit(cur_digit) : inc_digit(cur_digit);

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    idx_nxt   = idx;
    dec_nxt   = dec_q;
    load_nxt  = load_q;
    count_nxt = count_q;
    case (state)
      IDLE: begin
        if (bus.Request) begin
          div_nxt = '0;
          idx_nxt = '0;
          dec_nxt = bus.Dec;
          // Wraps at the top limit are performed as a whole-word load.
          if (bus.Set) begin
            state_nxt = LOAD;
            load_nxt  = bus.In;
          end else if (TOP_LIMIT_MODE != 0 && !bus.Dec && count_q == TOP_VALUE) begin
            state_nxt = LOAD;
            load_nxt  = '0;
          end else if (TOP_LIMIT_MODE != 0 && bus.Dec && count_q == '0) begin
            state_nxt = LOAD;
            load_nxt  = TOP_VALUE;
          end else begin
            state_nxt = STEP;
          end
        end
      end
      LOAD: begin
        if (tick) begin
          div_nxt   = '0;
          count_nxt = load_q;
          state_nxt = IDLE;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      STEP: begin
        if (tick) begin
          div_nxt                     = '0;
          count_nxt[int'(idx)*4 +: 4] = step_res[3:0];
          // Carry out of the top digit is dropped.
          if (step_res[4] && idx != IDX_W'(D_NUM - 1)) idx_nxt = idx + 1'b1;
          else state_nxt = IDLE;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      idx     <= '0;
      dec_q   <= 1'b0;
      load_q  <= '0;
      count_q <= '0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      idx     <= idx_nxt;
      dec_q   <= dec_nxt;
      load_q  <= load_nxt;
      count_q <= count_nxt;
    end
  end

  assign bus.Ready = (state == IDLE);
  assign bus.Out   = count_q;
endmodule

// File: tb/tb_dekatron_counter.sv
// Bench for dekatron_counter: instance A has a 0x255 top limit, instance B wraps
// at 999; a decimal-arithmetic model predicts final count and latency.
module tb_dekatron_counter;
  logic Clk = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   mv[2];

  always #5 Clk = ~Clk;

  dekatron_counter_if #(.D_NUM(3)) ifa ();
  dekatron_counter_if #(.D_NUM(3)) ifb ();

  dekatron_counter #(.D_NUM(3), .TOP_LIMIT_MODE(1), .TOP_VALUE(12'h255), .STEP_CYCLES(10))
    dut_a (.Clk(Clk), .Rst_n(rst_n_a), .bus(ifa));
  dekatron_counter #(.D_NUM(3), .TOP_LIMIT_MODE(0), .TOP_VALUE(12'h999), .STEP_CYCLES(10))
    dut_b (.Clk(Clk), .Rst_n(rst_n_b), .bus(ifb));

  typedef struct {
    bit         sel;
    bit         dec;
    bit         set;
    logic [11:0] in;
    logic [11:0] exp_out;
    int          exp_lat;
  } vec_t;
  vec_t vt[17];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int to_bcd(input int v);
    return (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic int from_bcd(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic rdy(input bit sel);
    return sel ? ifb.Ready : ifa.Ready;
  endfunction

  function automatic logic [11:0] outv(input bit sel);
    return sel ? ifb.Out : ifa.Out;
  endfunction

  task automatic drive(input bit sel, input logic r, input logic d, input logic s, input logic [11:0] in);
    if (sel) begin
      ifb.Request = r; ifb.Dec = d; ifb.Set = s; ifb.In = in;
    end else begin
      ifa.Request = r; ifa.Dec = d; ifa.Set = s; ifa.In = in;
    end
  endtask

  // Model: A wraps 255<->0 by load; otherwise decimal mod 1000, one step per
  // trailing 9 (up) or trailing 0 (down), capped at three decades.
  task automatic model_op(input bit sel, input bit dec, input bit set, input logic [11:0] in,
                          output int exp_v, output int exp_lat);
    int v, t, k;
    bit top;
    top = (sel == 1'b0);
    v = mv[sel];
    if (set) begin
      v = from_bcd(in); k = 1;
    end else if (top && !dec && v == 255) begin
      v = 0; k = 1;
    end else if (top && dec && v == 0) begin
      v = 255; k = 1;
    end else begin
      k = 1; t = v;
      while (k < 3 && (t % 10) == (dec ? 0 : 9)) begin
        k++; t = t / 10;
      end
      v = dec ? (v + 999) % 1000 : (v + 1) % 1000;
    end
    mv[sel] = v;
    exp_v = v;
    exp_lat = k * 10;
  endtask

  // Issue one request and count edges until Ready rises; junk is driven while busy.
  task automatic run_op(input bit sel, input bit dec, input bit set, input logic [11:0] in,
                        output logic [11:0] got, output int lat);
    @(negedge Clk);
    check("ready_before_request", int'(rdy(sel)), 1);
    drive(sel, 1'b1, dec, set, in);
    @(posedge Clk);
    #1;
    lat = 0;
    forever begin
      drive(sel, 1'($urandom), 1'($urandom), 1'($urandom), 12'($urandom));
      @(posedge Clk);
      #1;
      lat++;
      if (rdy(sel)) break;
      if (lat >= 200) begin
        check("ready_timeout", 0, 1);
        break;
      end
    end
    drive(sel, 1'b0, 1'b0, 1'b0, 12'h000);
    got = outv(sel);
  endtask

  task automatic chk_op(input string nm, input bit sel, input bit dec, input bit set,
                        input logic [11:0] in, input bit per_digit);
    int ev, el, lat;
    logic [11:0] got, expb;
    model_op(sel, dec, set, in, ev, el);
    run_op(sel, dec, set, in, got, lat);
    expb = 12'(to_bcd(ev));
    if (per_digit) begin
      for (int d = 0; d < 3; d++)
        check({nm, "_digit"}, int'(got[d*4 +: 4]), int'(expb[d*4 +: 4]));
    end else begin
      check({nm, "_out"}, int'(got), int'(expb));
    end
    check({nm, "_latency"}, lat, el);
  endtask

  initial begin
    logic [11:0] got;
    int lat;
    logic [11:0] rin;
    bit rset, rdec;

    vt[0]  = '{0, 0, 1, 12'h123, 12'h123, 10};
    vt[1]  = '{0, 0, 0, 12'h000, 12'h124, 10};
    vt[2]  = '{0, 0, 1, 12'h009, 12'h009, 10};
    vt[3]  = '{0, 0, 0, 12'h000, 12'h010, 20};
    vt[4]  = '{0, 1, 0, 12'h000, 12'h009, 20};
    vt[5]  = '{0, 0, 1, 12'h255, 12'h255, 10};
    vt[6]  = '{0, 0, 0, 12'h000, 12'h000, 10};
    vt[7]  = '{0, 1, 0, 12'h000, 12'h255, 10};
    vt[8]  = '{0, 0, 1, 12'h000, 12'h000, 10};
    vt[9]  = '{1, 0, 1, 12'h999, 12'h999, 10};
    vt[10] = '{1, 0, 0, 12'h000, 12'h000, 30};
    vt[11] = '{1, 1, 0, 12'h000, 12'h999, 30};
    vt[12] = '{1, 0, 1, 12'h00A, 12'h00A, 10};
    vt[13] = '{1, 0, 0, 12'h000, 12'h010, 20};
    vt[14] = '{1, 0, 1, 12'h099, 12'h099, 10};
    vt[15] = '{1, 0, 0, 12'h000, 12'h100, 30};
    vt[16] = '{1, 0, 1, 12'h000, 12'h000, 10};

    drive(0, 1'b0, 1'b0, 1'b0, 12'h000);
    drive(1, 1'b0, 1'b0, 1'b0, 12'h000);
    mv[0] = 0;
    mv[1] = 0;
    #22;
    check("reset_out_a", int'(ifa.Out), 0);
    check("reset_ready_a", int'(ifa.Ready), 1);
    @(negedge Clk);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    check("idle_out_a", int'(ifa.Out), 0);
    check("idle_ready_a", int'(ifa.Ready), 1);
    check("idle_out_b", int'(ifb.Out), 0);

    for (int i = 0; i < 17; i++) begin
      run_op(vt[i].sel, vt[i].dec, vt[i].set, vt[i].in, got, lat);
      check($sformatf("vec%0d_out", i), int'(got), int'(vt[i].exp_out));
      check($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
      mv[vt[i].sel] = from_bcd(vt[i].exp_out);
    end

    for (int i = 0; i < 50; i++) chk_op("inc50", 0, 1'b0, 1'b0, 12'h000, 1'b1);
    for (int i = 0; i < 50; i++) chk_op("dec50", 0, 1'b1, 1'b0, 12'h000, 1'b1);
    check("dec50_end", int'(ifa.Out), 0);

    // Borrow ripple: digit 0 must read 9 while digit 1 still holds 1.
    chk_op("ripple_set", 0, 1'b0, 1'b1, 12'h010, 1'b0);
    @(negedge Clk);
    drive(0, 1'b1, 1'b1, 1'b0, 12'h000);
    @(posedge Clk);
    #1;
    drive(0, 1'b0, 1'b0, 1'b0, 12'h000);
    repeat (10) @(posedge Clk);
    #1;
    check("ripple_mid_out", int'(ifa.Out), 12'h019);
    check("ripple_mid_ready", int'(ifa.Ready), 0);
    repeat (10) @(posedge Clk);
    #1;
    check("ripple_end_out", int'(ifa.Out), 12'h009);
    check("ripple_end_ready", int'(ifa.Ready), 1);
    mv[0] = 9;

    chk_op("zero_set", 0, 1'b0, 1'b1, 12'h000, 1'b0);
    for (int i = 0; i < 256; i++) chk_op("inc256", 0, 1'b0, 1'b0, 12'h000, 1'b0);
    check("inc256_end", int'(ifa.Out), 0);
    chk_op("dec_wrap", 0, 1'b1, 1'b0, 12'h000, 1'b0);

    for (int i = 0; i < 300; i++) begin
      bit sel;
      sel = 1'($urandom);
      rset = ($urandom_range(0, 3) == 0);
      rdec = 1'($urandom);
      case ($urandom_range(0, 3))
        0: rin = 12'h255;
        1: rin = 12'h000;
        default: rin = 12'(to_bcd($urandom_range(0, 999)));
      endcase
      chk_op("random", sel, rdec, rset, rin, 1'b0);
    end

    // Asynchronous reset in the middle of a 999 -> 000 ripple on B.
    chk_op("rst_set", 1, 1'b0, 1'b1, 12'h999, 1'b0);
    @(negedge Clk);
    drive(1, 1'b1, 1'b0, 1'b0, 12'h000);
    @(posedge Clk);
    #1;
    drive(1, 1'b0, 1'b0, 1'b0, 12'h000);
    repeat (15) @(posedge Clk);
    #1;
    check("rst_mid_out", int'(ifb.Out), 12'h990);
    #2;
    rst_n_b = 1'b0;
    #1;
    check("rst_async_out", int'(ifb.Out), 0);
    check("rst_async_ready", int'(ifb.Ready), 1);
    @(negedge Clk);
    rst_n_b = 1'b1;
    mv[1] = 0;
    chk_op("after_rst", 1, 1'b0, 1'b0, 12'h000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dekatron_counter.md
Name: dekatron_counter

Overview:
- Multi-decade BCD up/down counter that emulates a chain of dekatron tubes, one 4-bit digit per tube.
- A single request performs one increment, one decrement or one parallel load.
- Digit stepping is paced by an internal divider: each tube step or load takes a fixed number of clock cycles.
- Carries and borrows ripple tube by tube. Completion is reported with a Ready handshake to the instruction/address sequencer.

Parameters:
- D_NUM, 3, number of decades (tubes); counter width is D_NUM*4 bits, digit 0 in bits [3:0].
- TOP_LIMIT_MODE, 0, 1 = counter wraps at TOP_VALUE instead of at all-9s.
- TOP_VALUE, all digits 9, BCD wrap limit used when TOP_LIMIT_MODE=1.
- STEP_CYCLES, 10, Clk cycles per tube step or load (internal clock-divider ratio, ≥2).

Ports:
- Clk  in  1  sole clock; all logic on its rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Request  in  1  operation request, sampled on the rising edge of Clk.
- Dec  in  1  0 = increment, 1 = decrement; sampled at accept.
- Set  in  1  1 = load In instead of counting; sampled at accept.
- In  in  D_NUM*4  BCD load value.
- Ready  out  1  1 = idle and able to accept a request.
- Out  out  D_NUM*4  current BCD count.

Behaviour:
- Reset (Rst_n=0, async): Out=0, Ready=1, state IDLE, divider cleared. Reset mid-operation aborts the operation with the same values.
- States:
  - IDLE
  - LOAD
  - STEP(i), i = current decade
- Accept rule: at a Clk edge with Ready=1 and Request=1, latch Dec/Set/In, set Ready<=0 and start the divider. Request while Ready=0 is ignored, with no queuing.
- Set=1 at accept → LOAD. After STEP_CYCLES cycles all digits take In (no BCD validation), Ready<=1 on the same edge. Latency STEP_CYCLES.
- Top-limit wrap, TOP_LIMIT_MODE=1 only; both cases are handled as LOAD and take STEP_CYCLES:
  - Increment with Out==TOP_VALUE → loads all zeros.
  - Decrement with Out==0 → loads TOP_VALUE.
- Count, otherwise → STEP(0). Each STEP(i) waits STEP_CYCLES cycles, then updates digit i:
  - Increment: digit==9 → 0 with carry, else +1. A digit >9 is treated as 9 (becomes 0 with carry).
  - Decrement: digit==0 → 9 with borrow, else −1.
  - Carry/borrow with i<D_NUM−1 → STEP(i+1). Otherwise → IDLE, and Ready<=1 on the same edge as the final digit write.
  - Carry out of the top digit is discarded. With TOP_LIMIT_MODE=0, 99..9+1 → 0 and 0−1 → 99..9.
- Latency: STEP_CYCLES × (number of decades stepped), measured from the accept edge to the edge where Ready rises.
- Out changes only at digit-write edges. Lower digits are final before upper digits ripple. Out is fully settled when Ready rises.
- Dec, Set and In may change freely while Ready=0 without effect.
- Back-to-back: a request may be accepted on the first edge after Ready rises.

Test Plan:
- Default D_NUM=3, STEP_CYCLES=10. Reset pulse → Out=0x000, Ready=1; no request → Out stays 0, Ready stays 1.
- Setup: TOP_LIMIT_MODE=1, TOP_VALUE=0x255. Run 50 increment requests, checking after each Ready rise → Out equals BCD of the count 1..50, each digit individually. Latency for 0x009→0x010 is 20 cycles; for 0x001→0x002 it is 10 cycles.
- Then run 50 decrement requests (Dec=1) → Out counts 49..0 and ends at 0x000. For 0x010→0x009, digit 0 reaches 9 before digit 1 reaches 0.
- 256 increments from 0 → passes 0x255 and ends at 0x000; the 0x255→0x000 step takes 10 cycles. Decrement at 0x000 → 0x255.
- Set=1, In=0x123 with Request → after 10 cycles Out=0x123, Ready=1. Toggle Request while Ready=0 → ignored.
- TOP_LIMIT_MODE=0: from 0x999, increment → 0x000 after 30 cycles; decrement from 0x000 → 0x999. Assert Rst_n=0 mid-ripple → immediate Out=0x000, Ready=1.
